// File: rtl/rpn_engine.sv
// rpn_engine: postfix (RPN) evaluation controller. Consumes operand/operator tokens and drives
// the push/pop port of an 8-bit operand stack. The local occupancy count is authoritative; the
// stack's own empty/full flags are not used.
module rpn_engine #(
  parameter int unsigned SIZE = 100  // stack depth in entries, at most 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic       tok_is_op,
  input  logic [7:0] tok_data,
  output logic       stk_push_en,
  output logic       stk_pop_en,
  output logic [7:0] stk_data_in,
  input  logic [7:0] stk_data_out,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       err_underflow,
  output logic       err_overflow,
  output logic       err_badop,
  input  logic       err_clr
);

  // Operator token codes (ASCII)
  localparam logic [7:0] CodeAdd = 8'h2B;
  localparam logic [7:0] CodeSub = 8'h2D;
  localparam logic [7:0] CodeMul = 8'h2A;
  localparam logic [7:0] CodeEq  = 8'h3D;

  localparam logic [7:0] SizeCnt = 8'(SIZE);

  typedef enum logic [2:0] {
    StIdle,
    StPush,
    StPopB,
    StPopA,
    StCompute
  } state_e;

  typedef enum logic [1:0] {
    AluAdd,
    AluSub,
    AluMul
  } alu_op_e;

  state_e     state_q, state_d;
  alu_op_e    alu_op_q, alu_op_d;
  alu_op_e    alu_sel;
  logic [7:0] count_q, count_d;
  logic [7:0] push_q, push_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] result_q, result_d;
  logic       result_valid_q, result_valid_d;
  logic       err_uf_q, err_uf_d;
  logic       err_of_q, err_of_d;
  logic       err_bad_q, err_bad_d;
  logic       uf_set, of_set, bad_set;
  logic [7:0] alu_res;

  // Map the operator code onto the ALU selector that COMPUTE will use
  always_comb begin
    alu_sel = AluAdd;
    if (tok_data == CodeSub) begin
      alu_sel = AluSub;
    end else if (tok_data == CodeMul) begin
      alu_sel = AluMul;
    end
  end

  // 8-bit modulo arithmetic; a is the earlier-pushed operand
  always_comb begin
    alu_res = a_q + b_q;
    unique case (alu_op_q)
      AluAdd:  alu_res = a_q + b_q;
      AluSub:  alu_res = a_q - b_q;
      AluMul:  alu_res = a_q * b_q;
      default: alu_res = a_q + b_q;
    endcase
  end

  // Next-state logic: token decode in IDLE, then the fixed pop/pop/compute/push sequence
  always_comb begin
    state_d        = state_q;
    alu_op_d       = alu_op_q;
    count_d        = count_q;
    push_d         = push_q;
    a_d            = a_q;
    b_d            = b_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    uf_set         = 1'b0;
    of_set         = 1'b0;
    bad_set        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tok_valid) begin
          if (!tok_is_op) begin
            if (count_q < SizeCnt) begin
              push_d  = tok_data;
              state_d = StPush;
            end else begin
              of_set = 1'b1;
            end
          end else begin
            unique case (tok_data)
              CodeAdd, CodeSub, CodeMul: begin
                if (count_q >= 8'd2) begin
                  alu_op_d = alu_sel;
                  state_d  = StPopB;
                end else begin
                  uf_set = 1'b1;
                end
              end
              CodeEq: begin
                // Report top of stack without popping it
                if (count_q != 8'd0) begin
                  result_d       = stk_data_out;
                  result_valid_d = 1'b1;
                end else begin
                  uf_set = 1'b1;
                end
              end
              default: bad_set = 1'b1;
            endcase
          end
        end
      end
      StPush: begin
        count_d = count_q + 8'd1;
        state_d = StIdle;
      end
      StPopB: begin
        b_d     = stk_data_out;
        count_d = count_q - 8'd1;
        state_d = StPopA;
      end
      StPopA: begin
        a_d     = stk_data_out;
        count_d = count_q - 8'd1;
        state_d = StCompute;
      end
      StCompute: begin
        push_d  = alu_res;
        state_d = StPush;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky error flags: a new error in the same cycle as err_clr wins
  always_comb begin
    err_uf_d  = uf_set | (err_uf_q & ~err_clr);
    err_of_d  = of_set | (err_of_q & ~err_clr);
    err_bad_d = bad_set | (err_bad_q & ~err_clr);
  end

  // State and datapath registers; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      alu_op_q       <= AluAdd;
      count_q        <= 8'd0;
      push_q         <= 8'd0;
      a_q            <= 8'd0;
      b_q            <= 8'd0;
      result_q       <= 8'd0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_op_q       <= alu_op_d;
      count_q        <= count_d;
      push_q         <= push_d;
      a_q            <= a_d;
      b_q            <= b_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Error flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_uf_q  <= 1'b0;
      err_of_q  <= 1'b0;
      err_bad_q <= 1'b0;
    end else begin
      err_uf_q  <= err_uf_d;
      err_of_q  <= err_of_d;
      err_bad_q <= err_bad_d;
    end
  end

  // Moore-decoded handshake and stack strobes
  always_comb begin
    tok_ready     = (state_q == StIdle);
    stk_push_en   = (state_q == StPush);
    stk_pop_en    = (state_q == StPopB) || (state_q == StPopA);
    stk_data_in   = push_q;
    result        = result_q;
    result_valid  = result_valid_q;
    err_underflow = err_uf_q;
    err_overflow  = err_of_q;
    err_badop     = err_bad_q;
  end

endmodule

// File: tb/tb_rpn_engine.sv
// Bench for rpn_engine: a behavioural stack model emulates the operand stack, a token-level
// reference model predicts the per-cycle outputs, and one compare process checks them.
module tb_rpn_engine;

  localparam int unsigned SIZE = 4;

  logic       clk;
  logic       rst;
  logic       tok_valid;
  logic       tok_ready;
  logic       tok_is_op;
  logic [7:0] tok_data;
  logic       stk_push_en;
  logic       stk_pop_en;
  logic [7:0] stk_data_in;
  logic [7:0] stk_data_out;
  logic [7:0] result;
  logic       result_valid;
  logic       err_underflow;
  logic       err_overflow;
  logic       err_badop;
  logic       err_clr;

  rpn_engine #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_is_op    (tok_is_op),
    .tok_data     (tok_data),
    .stk_push_en  (stk_push_en),
    .stk_pop_en   (stk_pop_en),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .result       (result),
    .result_valid (result_valid),
    .err_underflow(err_underflow),
    .err_overflow (err_overflow),
    .err_badop    (err_badop),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand stack emulation, reset from the same source as the DUT
  logic [7:0] smem [0:255];
  logic [7:0] ssp;
  assign stk_data_out = (ssp != 8'd0) ? smem[ssp - 8'd1] : 8'h00;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ssp <= 8'd0;
    end else if (stk_push_en && ssp < 8'(SIZE)) begin
      smem[ssp] <= stk_data_in;
      ssp       <= ssp + 8'd1;
    end else if (stk_pop_en && ssp != 8'd0) begin
      ssp <= ssp - 8'd1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs per cycle after an accept, plus persistent state
  typedef struct {
    logic       ready;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic       rv;
    logic [7:0] res;
    logic       uf;
    logic       ovf;
    logic       bad;
  } rec_t;

  rec_t       q[$];
  logic [7:0] mstk[$];
  logic [7:0] m_din, m_res;
  logic       m_uf, m_ovf, m_bad;

  function automatic rec_t idle_rec();
    rec_t r;
    r.ready = 1'b1; r.push = 1'b0; r.pop = 1'b0; r.din = m_din; r.rv = 1'b0;
    r.res = m_res; r.uf = m_uf; r.ovf = m_ovf; r.bad = m_bad;
    return r;
  endfunction

  function automatic void model_reset();
    q.delete();
    mstk.delete();
    m_din = 8'h00; m_res = 8'h00;
    m_uf = 1'b0; m_ovf = 1'b0; m_bad = 1'b0;
  endfunction

  function automatic void model_accept(input logic is_op, input logic [7:0] d);
    rec_t       r;
    logic [7:0] a, b, y;
    if (err_clr) begin
      m_uf = 1'b0; m_ovf = 1'b0; m_bad = 1'b0;
    end
    if (!is_op) begin
      if (mstk.size() < SIZE) begin
        m_din = d;
        r = idle_rec(); r.ready = 1'b0; r.push = 1'b1;
        q.push_back(r);
        mstk.push_back(d);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (d == 8'h2B || d == 8'h2D || d == 8'h2A) begin
      if (mstk.size() >= 2) begin
        b = mstk.pop_back();
        a = mstk.pop_back();
        if (d == 8'h2B) y = a + b;
        else if (d == 8'h2D) y = a - b;
        else y = a * b;
        r = idle_rec(); r.ready = 1'b0; r.pop = 1'b1;
        q.push_back(r);
        q.push_back(r);
        r.pop = 1'b0;
        q.push_back(r);
        m_din = y;
        r.din = y; r.push = 1'b1;
        q.push_back(r);
        mstk.push_back(y);
      end else begin
        m_uf = 1'b1;
      end
    end else if (d == 8'h3D) begin
      if (mstk.size() >= 1) begin
        m_res = mstk[$];
        r = idle_rec(); r.rv = 1'b1;
        q.push_back(r);
      end else begin
        m_uf = 1'b1;
      end
    end else begin
      m_bad = 1'b1;
    end
  endfunction

  int         n_push = 0;
  int         n_pop  = 0;
  logic [7:0] last_push = 8'h00;
  logic [7:0] seen_res  = 8'h00;

  // Compare every cycle while out of reset
  always @(negedge clk) begin
    rec_t e;
    if (rst) begin
      if (q.size() > 0) e = q.pop_front();
      else e = idle_rec();
      chk("tok_ready", 32'(tok_ready), 32'(e.ready));
      chk("stk_push_en", 32'(stk_push_en), 32'(e.push));
      chk("stk_pop_en", 32'(stk_pop_en), 32'(e.pop));
      chk("stk_data_in", 32'(stk_data_in), 32'(e.din));
      chk("result_valid", 32'(result_valid), 32'(e.rv));
      chk("result", 32'(result), 32'(e.res));
      chk("err_underflow", 32'(err_underflow), 32'(e.uf));
      chk("err_overflow", 32'(err_overflow), 32'(e.ovf));
      chk("err_badop", 32'(err_badop), 32'(e.bad));
      if (stk_push_en) begin
        n_push++;
        last_push = stk_data_in;
      end
      if (stk_pop_en) n_pop++;
      if (result_valid) seen_res = result;
    end
  end

  task automatic send(input logic is_op, input logic [7:0] d);
    int w;
    w = 0;
    while (tok_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (tok_ready !== 1'b1) begin
      chk("accept_wait", 32'(tok_ready), 32'd1);
      return;
    end
    tok_valid = 1'b1; tok_is_op = is_op; tok_data = d;
    @(posedge clk); #1;
    tok_valid = 1'b0;
    model_accept(is_op, d);
  endtask

  task automatic num(input logic [7:0] d);
    send(1'b0, d);
  endtask

  task automatic op(input logic [7:0] d);
    send(1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_push_en", 32'(stk_push_en), 32'd0);
    chk("rst_pop_en", 32'(stk_pop_en), 32'd0);
    chk("rst_data_in", 32'(stk_data_in), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_err_underflow", 32'(err_underflow), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    chk("rst_err_badop", 32'(err_badop), 32'd0);
  endtask

  // Assert reset mid-cycle (asynchronously), check outputs, release away from an edge
  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, o0;
    rst = 1'b0; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = 8'h00; err_clr = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // 3 4 + = -> 7
    p0 = n_push; o0 = n_pop;
    num(8'd3); num(8'd4); op(8'h2B); op(8'h3D);
    idle(2);
    chk("add_result", 32'(seen_res), 32'h07);
    chk("add_pushes", 32'(n_push - p0), 32'd3);
    chk("add_pops", 32'(n_pop - o0), 32'd2);
    chk("add_depth", 32'(mstk.size()), 32'd1);

    // 5 7 - = -> 5-7 = 0xFE
    num(8'd5); num(8'd7); op(8'h2D); op(8'h3D);
    idle(2);
    chk("sub_result", 32'(seen_res), 32'hFE);

    // 20 13 * -> 260 mod 256 = 0x04
    num(8'd20); num(8'd13); op(8'h2A);
    idle(5);
    chk("mul_push", 32'(last_push), 32'h04);

    // Underflow on a one-deep stack, then clear
    apply_reset();
    p0 = n_push; o0 = n_pop;
    num(8'd9); op(8'h2B);
    idle(3);
    chk("uf_flag", 32'(err_underflow), 32'd1);
    chk("uf_pushes", 32'(n_push - p0), 32'd1);
    chk("uf_pops", 32'(n_pop - o0), 32'd0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_uf = 1'b0; m_ovf = 1'b0; m_bad = 1'b0;
    idle(1);
    chk("uf_cleared", 32'(err_underflow), 32'd0);

    // Overflow: fifth operand rejected, = returns the fourth
    apply_reset();
    p0 = n_push;
    num(8'd1); num(8'd2); num(8'd3); num(8'd4); num(8'd5);
    idle(2);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_pushes", 32'(n_push - p0), 32'd4);
    op(8'h3D);
    idle(2);
    chk("ovf_top", 32'(seen_res), 32'd4);

    // Unknown operator code
    op(8'h2F);
    idle(1);
    chk("badop_flag", 32'(err_badop), 32'd1);
    chk("badop_ready", 32'(tok_ready), 32'd1);

    // err_clr together with a new error: the error wins, other flags clear
    err_clr = 1'b1;
    op(8'h2F);
    err_clr = 1'b0;
    idle(1);
    chk("clr_vs_err_bad", 32'(err_badop), 32'd1);
    chk("clr_vs_err_ovf", 32'(err_overflow), 32'd0);

    // Reset during POPA of an add on a full stack
    op(8'h2B);
    apply_reset();
    p0 = n_push;
    idle(2);
    chk("post_rst_ready", 32'(tok_ready), 32'd1);
    chk("post_rst_no_push", 32'(n_push - p0), 32'd0);
    op(8'h3D);
    idle(1);
    chk("post_rst_uf", 32'(err_underflow), 32'd1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
